// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: op encodings, decode constants and the per-stage
// control word used by the multiply (and later divide) pipelines.
package rv32m_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef struct packed {
        logic    valid;
        mul_op_e op;
        logic [4:0] tag;
    } mul_stage_t;

    // funct3[2] set means DIV/REM, which this unit does not handle
    function automatic logic is_mul(input logic [6:0] opcode, input logic [6:0] funct7,
                                    input logic funct3_msb);
        return (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV) && !funct3_msb;
    endfunction

endpackage

// File: rtl/rv32m_pipe_reg.sv
// One pipeline register stage with a valid bit: hold freezes it, flush kills
// the valid bit, and the data only loads when a valid item moves in.
module rv32m_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!hold_i) begin
            valid_d = valid_i;
        end
        if (valid_i && !hold_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/rv32m_mul_pipe.sv
// Fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with valid/tag
// result interface, global hold and flush; results emerge in order after STAGES.
module rv32m_mul_pipe
    import rv32m_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [31:0]     opcode_i,
    input  logic [XLEN-1:0] ra_i,
    input  logic [XLEN-1:0] rb_i,
    input  logic            hold_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      tag_o
);

    localparam int H    = XLEN / 2;
    localparam int PPW  = XLEN + 2;
    localparam int PW   = 2 * XLEN;
    localparam int NREG = (STAGES == 2) ? 1 : STAGES - 2;
    localparam int DW   = 5 + XLEN;

    logic    accept;
    mul_op_e dec_op;
    logic    unused_opcode_bits;

    assign ready_o            = !hold_i;
    assign dec_op             = mul_op_e'(opcode_i[13:12]);
    assign accept             = valid_i && !hold_i && !flush_i &&
                                is_mul(opcode_i[6:0], opcode_i[31:25], opcode_i[14]);
    assign unused_opcode_bits = ^opcode_i[24:15];

    // Sums the four partial products modulo 2^(2*XLEN) and picks the half
    function automatic logic [XLEN-1:0] combine(input logic [3:0][PPW-1:0] p,
                                                input mul_op_e op);
        logic [PW-1:0] hh, hl, lh, ll, sum;
        hh  = {{(PW-PPW){p[3][PPW-1]}}, p[3]};
        hl  = {{(PW-PPW){p[2][PPW-1]}}, p[2]};
        lh  = {{(PW-PPW){p[1][PPW-1]}}, p[1]};
        ll  = {{(PW-PPW){p[0][PPW-1]}}, p[0]};
        sum = (hh << XLEN) + (hl << H) + (lh << H) + ll;
        return (op == MUL) ? sum[XLEN-1:0] : sum[PW-1:XLEN];
    endfunction

    mul_stage_t    s1_d, s1_q;
    logic [XLEN:0] a1_d, a1_q, b1_d, b1_q;

    always_comb begin
        s1_d = s1_q;
        a1_d = a1_q;
        b1_d = b1_q;
        if (flush_i) begin
            s1_d.valid = 1'b0;
        end else if (!hold_i) begin
            s1_d.valid = accept;
        end
        if (accept) begin
            s1_d.op  = dec_op;
            s1_d.tag = opcode_i[11:7];
            a1_d     = {((dec_op == MULH) || (dec_op == MULHSU)) && ra_i[XLEN-1], ra_i};
            b1_d     = {(dec_op == MULH) && rb_i[XLEN-1], rb_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            a1_q <= '0;
            b1_q <= '0;
        end else begin
            s1_q <= s1_d;
            a1_q <= a1_d;
            b1_q <= b1_d;
        end
    end

    // Upper halves are signed (H+1 bits), lower halves unsigned (H bits)
    logic [PPW-1:0]        ah_x, al_x, bh_x, bl_x;
    logic [3:0][PPW-1:0]   pp;

    always_comb begin
        ah_x  = {{(PPW-H-1){a1_q[XLEN]}}, a1_q[XLEN:H]};
        bh_x  = {{(PPW-H-1){b1_q[XLEN]}}, b1_q[XLEN:H]};
        al_x  = {{(PPW-H){1'b0}}, a1_q[H-1:0]};
        bl_x  = {{(PPW-H){1'b0}}, b1_q[H-1:0]};
        pp[3] = ah_x * bh_x;
        pp[2] = ah_x * bl_x;
        pp[1] = al_x * bh_x;
        pp[0] = al_x * bl_x;
    end

    logic          head_valid;
    logic [DW-1:0] head_data;

    generate
        if (STAGES == 2) begin : g_merged
            assign head_valid = s1_q.valid;
            assign head_data  = {s1_q.tag, combine(pp, s1_q.op)};
        end else begin : g_split
            mul_stage_t          s2_d, s2_q;
            logic [3:0][PPW-1:0] pp2_d, pp2_q;

            always_comb begin
                s2_d  = s2_q;
                pp2_d = pp2_q;
                if (flush_i) begin
                    s2_d.valid = 1'b0;
                end else if (!hold_i) begin
                    s2_d.valid = s1_q.valid;
                end
                if (s1_q.valid && !hold_i) begin
                    s2_d.op  = s1_q.op;
                    s2_d.tag = s1_q.tag;
                    pp2_d    = pp;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    s2_q  <= '0;
                    pp2_q <= '0;
                end else begin
                    s2_q  <= s2_d;
                    pp2_q <= pp2_d;
                end
            end

            assign head_valid = s2_q.valid;
            assign head_data  = {s2_q.tag, combine(pp2_q, s2_q.op)};
        end
    endgenerate

    logic [NREG-1:0]         chain_valid;
    logic [NREG-1:0][DW-1:0] chain_data;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_delay
            if (i == 0) begin : g_first
                rv32m_pipe_reg #(.WIDTH(DW)) u_reg (
                    .clk_i  (clk_i),
                    .rst_ni (rst_ni),
                    .hold_i (hold_i),
                    .flush_i(flush_i),
                    .valid_i(head_valid),
                    .data_i (head_data),
                    .valid_o(chain_valid[i]),
                    .data_o (chain_data[i])
                );
            end else begin : g_next
                rv32m_pipe_reg #(.WIDTH(DW)) u_reg (
                    .clk_i  (clk_i),
                    .rst_ni (rst_ni),
                    .hold_i (hold_i),
                    .flush_i(flush_i),
                    .valid_i(chain_valid[i-1]),
                    .data_i (chain_data[i-1]),
                    .valid_o(chain_valid[i]),
                    .data_o (chain_data[i])
                );
            end
        end
    endgenerate

    assign valid_o           = chain_valid[NREG-1];
    assign {tag_o, result_o} = chain_data[NREG-1];

endmodule

// File: tb/tb_rv32m_mul_pipe.sv
// Scoreboard bench for rv32m_mul_pipe: a 32-bit/4-stage and a 64-bit/2-stage
// instance share control inputs and are checked against a wide arithmetic model.
module tb_rv32m_mul_pipe;

    localparam int STG_A = 4;
    localparam int STG_B = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, hold, flush;
    logic [31:0] opcode;
    logic [31:0] ra32, rb32;
    logic [63:0] ra64, rb64;

    logic        ready32, valid32, ready64, valid64;
    logic [31:0] res32;
    logic [63:0] res64;
    logic [4:0]  tag32, tag64;

    always #5 clk = ~clk;

    rv32m_mul_pipe #(.XLEN(32), .STAGES(STG_A)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .opcode_i(opcode),
        .ra_i(ra32), .rb_i(rb32), .hold_i(hold), .flush_i(flush),
        .ready_o(ready32), .valid_o(valid32), .result_o(res32), .tag_o(tag32)
    );

    rv32m_mul_pipe #(.XLEN(64), .STAGES(STG_B)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .opcode_i(opcode),
        .ra_i(ra64), .rb_i(rb64), .hold_i(hold), .flush_i(flush),
        .ready_o(ready64), .valid_o(valid64), .result_o(res64), .tag_o(tag64)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;
    int   adv    = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands as integers of width w, multiply exactly
    function automatic logic [63:0] refMul(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic signed [131:0] av, bv, p;
        logic [63:0]         r;
        av = '0;
        bv = '0;
        r  = '0;
        for (int i = 0; i < w; i++) begin
            av[i] = a[i];
            bv[i] = b[i];
        end
        if ((op == 2'd1 || op == 2'd2) && a[w-1]) av = av - (132'sd1 <<< w);
        if (op == 2'd1 && b[w-1]) bv = bv - (132'sd1 <<< w);
        p = av * bv;
        for (int i = 0; i < w; i++) r[i] = (op == 2'd0) ? p[i] : p[i+w];
        return r;
    endfunction

    function automatic logic isMulInsn(input logic [31:0] insn);
        return insn[6:0] == 7'h33 && insn[31:25] == 7'h01 && insn[14] == 1'b0;
    endfunction

    function automatic logic [31:0] mkOp(input logic [1:0] op, input logic [4:0] rd);
        return {7'b0000001, 5'($urandom), 5'($urandom), 1'b0, op, rd, 7'b0110011};
    endfunction

    function automatic logic [63:0] sx(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!hold) adv <= adv + 1;
    end

    // Drive one cycle of inputs; predict accepted ops and flush kills
    task automatic applyStimulus(input logic v, input logic [31:0] opc, input logic [63:0] a,
                                 input logic [63:0] b, input logic h, input logic f);
        valid  = v;
        opcode = opc;
        ra32   = a[31:0];
        rb32   = b[31:0];
        ra64   = a;
        rb64   = b;
        hold   = h;
        flush  = f;
        if (f) begin
            while (q32.size() > 0 && q32[$].due > adv) void'(q32.pop_back());
            while (q64.size() > 0 && q64[$].due > adv) void'(q64.pop_back());
        end
        if (v && !h && !f && rst_n && isMulInsn(opc)) begin
            q32.push_back('{refMul(opc[13:12], a, b, 32), opc[11:7], adv + STG_A});
            q64.push_back('{refMul(opc[13:12], a, b, 64), opc[11:7], adv + STG_B});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    logic        prevHold = 1'b0;
    logic        prevV32 = 1'b0, prevV64 = 1'b0;
    logic [31:0] prevR32 = '0;
    logic [63:0] prevR64 = '0;

    // Monitor: a result is consumed when presented on a non-held cycle
    always @(negedge clk) begin
        exp_t e;
        checkOutput("ready32", {63'h0, ready32}, {63'h0, !hold});
        checkOutput("ready64", {63'h0, ready64}, {63'h0, !hold});
        if (prevHold) begin
            checkOutput("frozen32", {31'h0, valid32, res32}, {31'h0, prevV32, prevR32});
            checkOutput("frozen64", {63'h0, valid64}, {63'h0, prevV64});
            checkOutput("frozen64_res", res64, prevR64);
        end
        if (valid32 && !hold) begin
            if (q32.size() == 0) begin
                checkOutput("unexpected32", {63'h0, valid32}, 64'h0);
            end else begin
                e = q32.pop_front();
                checkOutput("result32", {32'h0, res32}, e.res);
                checkOutput("tag32", {59'h0, tag32}, {59'h0, e.tag});
                checkOutput("latency32", adv, e.due);
            end
        end
        if (valid64 && !hold) begin
            if (q64.size() == 0) begin
                checkOutput("unexpected64", {63'h0, valid64}, 64'h0);
            end else begin
                e = q64.pop_front();
                checkOutput("result64", res64, e.res);
                checkOutput("tag64", {59'h0, tag64}, {59'h0, e.tag});
                checkOutput("latency64", adv, e.due);
            end
        end
        prevHold <= hold;
        prevV32  <= valid32;
        prevR32  <= res32;
        prevV64  <= valid64;
        prevR64  <= res64;
    end

    initial begin
        logic [31:0] opc;
        logic        h, f, v;
        rst_n  = 1'b1;
        valid  = 1'b0;
        hold   = 1'b0;
        flush  = 1'b0;
        opcode = '0;
        ra32   = '0;
        rb32   = '0;
        ra64   = '0;
        rb64   = '0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_valid32", {63'h0, valid32}, 64'h0);
        checkOutput("reset_result32", {32'h0, res32}, 64'h0);
        checkOutput("reset_tag32", {59'h0, tag32}, 64'h0);
        checkOutput("reset_valid64", {63'h0, valid64}, 64'h0);
        checkOutput("reset_result64", res64, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed operand pair, all four ops");
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, mkOp(2'(k), 5'(k + 1)), sx(32'h8000_0001), sx(32'h8001_0002), 1'b0, 1'b0);
        idle(6);

        $display("[TB] back-to-back ops");
        applyStimulus(1'b1, mkOp(2'd0, 5'd10), sx(32'd9), sx(32'd7), 1'b0, 1'b0);
        applyStimulus(1'b1, mkOp(2'd3, 5'd11), sx(32'hFFFF_FFFF), sx(32'hFFFF_FFFF), 1'b0, 1'b0);
        applyStimulus(1'b1, mkOp(2'd1, 5'd12), sx(32'hFFFF_FFFF), sx(32'hFFFF_FFFF), 1'b0, 1'b0);
        applyStimulus(1'b1, mkOp(2'd2, 5'd13), sx(32'hFFFF_FFFF), sx(32'hFFFF_FFFF), 1'b0, 1'b0);
        idle(6);

        $display("[TB] hold with two ops in flight");
        applyStimulus(1'b1, mkOp(2'd0, 5'd20), sx(32'h1234_5678), sx(32'h9ABC_DEF0), 1'b0, 1'b0);
        applyStimulus(1'b1, mkOp(2'd1, 5'd21), sx(32'hDEAD_BEEF), sx(32'h0BAD_F00D), 1'b0, 1'b0);
        opc = mkOp(2'd3, 5'd22);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, opc, sx(32'hCAFE_0001), sx(32'h7777_AAAA), 1'b1, 1'b0);
        applyStimulus(1'b1, opc, sx(32'hCAFE_0001), sx(32'h7777_AAAA), 1'b0, 1'b0);
        idle(6);

        $display("[TB] flush with three ops in flight");
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, mkOp(2'(k), 5'(k + 24)), sx($urandom), sx($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, mkOp(2'd0, 5'd27), sx(32'h55), sx(32'h66), 1'b0, 1'b1);
        applyStimulus(1'b1, mkOp(2'd1, 5'd28), sx(32'h8765_4321), sx(32'hF000_000F), 1'b0, 1'b0);
        idle(6);

        $display("[TB] asynchronous reset mid-flight");
        applyStimulus(1'b1, mkOp(2'd0, 5'd30), sx(32'h3), sx(32'h5), 1'b0, 1'b0);
        applyStimulus(1'b1, mkOp(2'd3, 5'd31), sx(32'h7), sx(32'hB), 1'b0, 1'b0);
        applyStimulus(1'b1, mkOp(2'd2, 5'd29), sx(32'hF), sx(32'h11), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid32", {63'h0, valid32}, 64'h0);
        checkOutput("midreset_result32", {32'h0, res32}, 64'h0);
        checkOutput("midreset_tag32", {59'h0, tag32}, 64'h0);
        checkOutput("midreset_valid64", {63'h0, valid64}, 64'h0);
        checkOutput("midreset_result64", res64, 64'h0);
        checkOutput("midreset_tag64", {59'h0, tag64}, 64'h0);
        q32.delete();
        q64.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 99) < 75);
            opc = mkOp(2'($urandom), 5'($urandom));
            case ($urandom_range(0, 9))
                0:       opc[31:25] = 7'h00;
                1:       opc[14]    = 1'b1;
                2:       opc[6:0]   = 7'h13;
                default: ;
            endcase
            h = ($urandom_range(0, 99) < 15);
            f = !h && ($urandom_range(0, 99) < 4);
            applyStimulus(v, opc, randOperand(), randOperand(), h, f);
        end

        for (int i = 0; i < 30 && (q32.size() > 0 || q64.size() > 0); i++) idle(1);
        idle(2);
        checkOutput("drain32", 64'(q32.size()), 64'h0);
        checkOutput("drain64", 64'(q64.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
